// File: rtl/ysyx_25020047_mem_arb.sv
// Two-master (IFU read-only, LSU read/write) arbiter in front of a single
// memory slave port. One transaction is in flight at a time and moves through
// IDLE -> REQ -> WAIT -> RESP. A consecutive-LSU counter stops the LSU from
// starving the IFU, and a timeout counter returns an error if the slave hangs.
module ysyx_25020047_mem_arb #(
    parameter int unsigned LSU_MAX = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_valid,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_ready,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        s_req,
    output logic        s_wen,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    input  logic        s_ready,
    input  logic        s_resp_valid,
    input  logic [31:0] s_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int unsigned CW = $clog2(TIMEOUT + 2);
    localparam int unsigned LW = $clog2(LSU_MAX + 2);

    logic [1:0]    r_state;
    logic          r_owner_lsu;
    logic          r_wen;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wmask;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_lcnt;

    logic w_in_idle;
    logic w_ifu_wins;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_expire;
    logic w_resp;

    // Arbitration and timeout decode. The expiry fires in the cycle whose
    // incremented count reaches TIMEOUT, so RESP lands TIMEOUT cycles after
    // entering REQ; ready is masked during reset so all outputs read 0.
    always_comb begin
        w_in_idle   = (r_state == S_IDLE) && !rst;
        w_ifu_wins  = ifu_valid && (!lsu_valid || (r_lcnt == LW'(LSU_MAX)));
        w_grant_ifu = w_in_idle && w_ifu_wins;
        w_grant_lsu = w_in_idle && lsu_valid && !w_ifu_wins;
        w_expire    = ((r_cnt + CW'(1)) == CW'(TIMEOUT));
        w_resp      = (r_state == S_RESP);
    end

    // Transaction sequencer: latch the winner, drive the slave, collect the
    // response or the timeout, present it for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_lsu <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_lcnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu) begin
                        r_owner_lsu <= 1'b0;
                        r_wen       <= 1'b0;
                        r_addr      <= ifu_addr;
                        r_wdata     <= '0;
                        r_wmask     <= '0;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_cnt       <= '0;
                        r_lcnt      <= '0;
                        r_state     <= S_REQ;
                    end else if (w_grant_lsu) begin
                        r_owner_lsu <= 1'b1;
                        r_wen       <= lsu_wen;
                        r_addr      <= lsu_addr;
                        r_wdata     <= lsu_wdata;
                        r_wmask     <= lsu_wmask;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_cnt       <= '0;
                        r_lcnt      <= ifu_valid ? (r_lcnt + LW'(1)) : '0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_expire) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (s_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (s_resp_valid) begin
                        r_rdata <= r_wen ? '0 : s_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive: slave side from latched fields, master side gated by owner.
    always_comb begin
        ifu_ready      = w_grant_ifu;
        lsu_ready      = w_grant_lsu;
        s_req          = (r_state == S_REQ);
        s_wen          = r_wen;
        s_addr         = r_addr;
        s_wdata        = r_wdata;
        s_wmask        = r_wmask;
        ifu_resp_valid = w_resp && !r_owner_lsu;
        lsu_resp_valid = w_resp && r_owner_lsu;
        ifu_rdata      = ifu_resp_valid ? r_rdata : '0;
        ifu_err        = ifu_resp_valid && r_err;
        lsu_rdata      = lsu_resp_valid ? r_rdata : '0;
        lsu_err        = lsu_resp_valid && r_err;
    end

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Directed bench for ysyx_25020047_mem_arb with LSU_MAX=4, TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_ysyx_25020047_mem_arb;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic [31:0] ifu_addr;
  logic        ifu_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_valid;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        s_req;
  logic        s_wen;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_ready;
  logic        s_resp_valid;
  logic [31:0] s_rdata;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  logic [9:0]  grant_ifu_order;

  ysyx_25020047_mem_arb #(.LSU_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_valid(lsu_valid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_ready(s_ready), .s_resp_valid(s_resp_valid),
    .s_rdata(s_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ok();
    n_total = n_total + 1;
    n_pass  = n_pass + 1;
  endtask

  task automatic bad(input string tag);
    n_total = n_total + 1;
    n_fail  = n_fail + 1;
    $error("FAIL %s", tag);
  endtask

  initial begin
    rst = 1'b1;
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    s_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
    #2;
    // reset: every output low even with requests pending
    if (ifu_ready === 1'b0) ok(); else bad("rst_ifu_ready");
    if (lsu_ready === 1'b0) ok(); else bad("rst_lsu_ready");
    if (s_req === 1'b0) ok(); else bad("rst_s_req");
    if (s_addr === 32'h0) ok(); else bad("rst_s_addr");
    if ({ifu_resp_valid, lsu_resp_valid} === 2'b00) ok(); else bad("rst_resp");
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // IFU-only read, slave ready after one cycle
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0000; #1;
    if (ifu_ready === 1'b1) ok(); else bad("t1_ifu_ready");
    if (lsu_ready === 1'b0) ok(); else bad("t1_lsu_ready");
    if (s_req === 1'b0) ok(); else bad("t1_s_req_c0");
    tick(); ifu_valid = 1'b0; #1;
    if (s_req === 1'b1) ok(); else bad("t1_s_req_c1");
    if (s_addr === 32'h8000_0000) ok(); else bad("t1_s_addr");
    if (s_wen === 1'b0) ok(); else bad("t1_s_wen");
    tick(); s_ready = 1'b1; #1;
    if (s_req === 1'b1) ok(); else bad("t1_s_req_c2");
    tick(); s_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'hDEAD_BEEF; #1;
    if (s_req === 1'b0) ok(); else bad("t1_s_req_c3");
    if (ifu_resp_valid === 1'b0) ok(); else bad("t1_resp_early");
    tick(); s_resp_valid = 1'b0; #1;
    if (ifu_resp_valid === 1'b1) ok(); else bad("t1_resp_valid");
    if (ifu_rdata === 32'hDEAD_BEEF) ok(); else bad("t1_rdata");
    if (ifu_err === 1'b0) ok(); else bad("t1_err");
    if (lsu_resp_valid === 1'b0) ok(); else bad("t1_lsu_resp");
    tick(); #1;
    if (ifu_resp_valid === 1'b0) ok(); else bad("t1_resp_once");

    // Simultaneous requests: LSU write first, IFU on the next IDLE
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF; #1;
    if (lsu_ready === 1'b1) ok(); else bad("t2_lsu_ready");
    if (ifu_ready === 1'b0) ok(); else bad("t2_ifu_ready");
    tick(); lsu_valid = 1'b0; s_ready = 1'b1; #1;
    if (s_req === 1'b1) ok(); else bad("t2_s_req");
    if (s_wen === 1'b1) ok(); else bad("t2_s_wen");
    if (s_addr === 32'h8000_1000) ok(); else bad("t2_s_addr");
    if (s_wdata === 32'h1234_5678) ok(); else bad("t2_s_wdata");
    if (s_wmask === 4'hF) ok(); else bad("t2_s_wmask");
    if (ifu_ready === 1'b0) ok(); else bad("t2_ifu_held_req");
    tick(); s_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'hAAAA_AAAA; #1;
    if (ifu_ready === 1'b0) ok(); else bad("t2_ifu_held_wait");
    tick(); s_resp_valid = 1'b0; #1;
    if (lsu_resp_valid === 1'b1) ok(); else bad("t2_lsu_resp");
    if (lsu_rdata === 32'h0) ok(); else bad("t2_lsu_rdata_write");
    if (lsu_err === 1'b0) ok(); else bad("t2_lsu_err");
    if (ifu_resp_valid === 1'b0) ok(); else bad("t2_ifu_resp_nonowner");
    if (ifu_ready === 1'b0) ok(); else bad("t2_ifu_held_resp");
    tick(); #1;
    if (ifu_ready === 1'b1) ok(); else bad("t2_ifu_ready_n4");
    tick(); ifu_valid = 1'b0; s_ready = 1'b1; #1;
    if (s_addr === 32'h8000_0004) ok(); else bad("t2_ifu_s_addr");
    if (s_wen === 1'b0) ok(); else bad("t2_ifu_s_wen");
    tick(); s_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'h0BAD_F00D; #1;
    tick(); s_resp_valid = 1'b0; #1;
    if (ifu_resp_valid === 1'b1) ok(); else bad("t2_ifu_resp");
    if (ifu_rdata === 32'h0BAD_F00D) ok(); else bad("t2_ifu_rdata");
    tick();

    // Starvation guard: both held high, order L,L,L,L,I,L,L,L,L,I
    grant_ifu_order = 10'b10_0001_0000;
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0008;
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000;
    for (int unsigned i = 0; i < 10; i++) begin
      #1;
      if (ifu_ready === grant_ifu_order[i]) ok(); else bad("t3_ifu_grant");
      if (lsu_ready === !grant_ifu_order[i]) ok(); else bad("t3_lsu_grant");
      tick(); s_ready = 1'b1;
      tick(); s_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'(i);
      tick(); s_resp_valid = 1'b0; #1;
      if ({ifu_resp_valid, lsu_resp_valid} === (grant_ifu_order[i] ? 2'b10 : 2'b01)) ok();
      else bad("t3_owner_resp");
      tick();
    end
    ifu_valid = 1'b0; lsu_valid = 1'b0;

    // Timeout: slave never accepts; error response 8 cycles after REQ
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000; #1;
    if (lsu_ready === 1'b1) ok(); else bad("t4_lsu_ready");
    tick(); lsu_valid = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      #1;
      if (s_req === 1'b1) ok(); else bad("t4_s_req_held");
      if (lsu_resp_valid === 1'b0) ok(); else bad("t4_no_resp_yet");
      tick();
    end
    #1;
    if (lsu_resp_valid === 1'b1) ok(); else bad("t4_resp_valid");
    if (lsu_err === 1'b1) ok(); else bad("t4_err");
    if (lsu_rdata === 32'h0) ok(); else bad("t4_rdata");
    if (s_req === 1'b0) ok(); else bad("t4_s_req_dropped");
    tick(); s_resp_valid = 1'b1; s_rdata = 32'hFFFF_FFFF; #1;
    if ({ifu_resp_valid, lsu_resp_valid} === 2'b00) ok(); else bad("t4_late_resp_idle");
    tick(); s_resp_valid = 1'b0; #1;
    if ({ifu_resp_valid, lsu_resp_valid} === 2'b00) ok(); else bad("t4_late_resp_after");
    if (s_req === 1'b0) ok(); else bad("t4_idle_s_req");

    // Reset in WAIT: aborted silently, stale response ignored
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0100; #1;
    if (ifu_ready === 1'b1) ok(); else bad("t5_ifu_ready");
    tick(); ifu_valid = 1'b0; s_ready = 1'b1;
    tick(); s_ready = 1'b0; rst = 1'b1; #1;
    if (s_req === 1'b0) ok(); else bad("t5_rst_s_req");
    if (s_addr === 32'h0) ok(); else bad("t5_rst_s_addr");
    tick(); rst = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'h5555_5555; #1;
    if ({ifu_resp_valid, lsu_resp_valid} === 2'b00) ok(); else bad("t5_stale_resp");
    tick(); s_resp_valid = 1'b0; #1;
    if ({ifu_resp_valid, lsu_resp_valid} === 2'b00) ok(); else bad("t5_stale_after");
    if (s_req === 1'b0) ok(); else bad("t5_idle_s_req");
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0200; #1;
    if (ifu_ready === 1'b1) ok(); else bad("t5_reissue_ready");
    tick(); ifu_valid = 1'b0; s_ready = 1'b1; #1;
    if (s_addr === 32'h8000_0200) ok(); else bad("t5_reissue_addr");
    tick(); s_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'h1122_3344;
    tick(); s_resp_valid = 1'b0; #1;
    if (ifu_resp_valid === 1'b1) ok(); else bad("t5_reissue_resp");
    if (ifu_rdata === 32'h1122_3344) ok(); else bad("t5_reissue_rdata");
    tick();

    // Response in the same cycle as expiry: response wins
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_4000; #1;
    if (lsu_ready === 1'b1) ok(); else bad("t6_lsu_ready");
    tick(); lsu_valid = 1'b0; s_ready = 1'b1;
    tick(); s_ready = 1'b0;
    for (int unsigned k = 0; k < 6; k++) tick();
    s_resp_valid = 1'b1; s_rdata = 32'hCAFE_F00D; #1;
    if (lsu_resp_valid === 1'b0) ok(); else bad("t6_no_resp_yet");
    tick(); s_resp_valid = 1'b0; #1;
    if (lsu_resp_valid === 1'b1) ok(); else bad("t6_resp_valid");
    if (lsu_err === 1'b0) ok(); else bad("t6_err");
    if (lsu_rdata === 32'hCAFE_F00D) ok(); else bad("t6_rdata");
    tick(); #1;
    if (lsu_resp_valid === 1'b0) ok(); else bad("t6_back_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_mem_arb.md
Name: ysyx_25020047_mem_arb

Overview:
- Two-master, one-slave memory arbiter with a transaction sequencer.
- Shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store path driven by the EXU's read/write/result outputs (LSU).
- Grants one transaction at a time and sequences request, wait and response phases.
- Guards against LSU starvation of the IFU and against a hung slave.

Parameters:
- LSU_MAX, 4: maximum consecutive LSU grants while IFU is waiting; after that, IFU wins the next arbitration.
- TIMEOUT, 255: maximum cycles from entering REQ to slave response; on expiry an error response is returned.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ifu_valid  in  1  IFU read request; held stable until ifu_ready
- ifu_addr  in  32  IFU read address
- ifu_ready  out  1  IFU request accepted (single-cycle pulse)
- ifu_resp_valid  out  1  IFU response strobe (one cycle)
- ifu_rdata  out  32  IFU read data
- ifu_err  out  1  IFU response error (timeout)
- lsu_valid  in  1  LSU request; held stable until lsu_ready
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  32  LSU address
- lsu_wdata  in  32  LSU write data
- lsu_wmask  in  4  LSU byte-lane write mask
- lsu_ready  out  1  LSU request accepted (single-cycle pulse)
- lsu_resp_valid  out  1  LSU response strobe (one cycle)
- lsu_rdata  out  32  LSU read data (0 for writes)
- lsu_err  out  1  LSU response error (timeout)
- s_req  out  1  slave request valid
- s_wen  out  1  slave write enable
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wmask  out  4  slave write mask
- s_ready  in  1  slave accepts request
- s_resp_valid  in  1  slave response valid
- s_rdata  in  32  slave read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0.
  - Grant owner cleared; consecutive-LSU counter cleared; timeout counter cleared.
- States:
  - IDLE: arbitrate. If any request is present, assert the winner's *_ready combinationally in the same cycle, latch its request fields and owner into registers, and go to REQ.
  - REQ: s_req=1; s_* driven from registers only. On s_ready=1, go to WAIT (s_req deasserts next cycle).
  - WAIT: on s_resp_valid=1, capture s_rdata (forced to 0 for writes) and go to RESP.
  - RESP: owner's *_resp_valid=1 with latched data/err for exactly one cycle, then IDLE.
- Arbitration:
  - LSU has priority by default.
  - If ifu_valid=1 and the consecutive-LSU counter equals LSU_MAX, IFU wins.
  - Counter increments on each LSU grant made while ifu_valid=1.
  - Counter clears on any IFU grant, or on an LSU grant with ifu_valid=0.
- Latency:
  - Accept in cycle N; s_req is first high in N+1.
  - Zero-wait slave (s_ready in N+1, s_resp_valid in N+2): resp_valid in N+3.
  - Next accept is possible in N+4.
- Timeout:
  - Counter resets on entering REQ and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT without the response: go to RESP with err=1, rdata=0, s_req dropped.
  - A response and the expiry in the same cycle: the response wins, err=0.
- Non-owner *_ready and *_resp_valid are always 0. Masters must accept responses; there is no back-pressure.
- s_resp_valid outside WAIT is ignored, including a stale response after reset or after a timeout.
- s_ready outside REQ is ignored.
- Reset mid-transaction aborts it silently. No response is issued to the owner; the master must reissue.
- Only one transaction is outstanding at a time. New requests are held off (ready=0) in REQ/WAIT/RESP.

Test Plan:
- IFU-only read: ifu_valid, addr 0x80000000; slave ready after 1 cycle, rdata 0xDEADBEEF after 2 -> ifu_ready in cycle 0, s_req cycles 1..2, ifu_resp_valid once with 0xDEADBEEF, ifu_err=0.
- Simultaneous requests: both valid, LSU write addr 0x80001000, wdata 0x12345678, wmask 0xF -> LSU granted first with s_wen=1 and lsu_rdata=0; IFU granted on the next IDLE.
- Starvation guard, LSU_MAX=4: lsu_valid and ifu_valid held high continuously -> grant order L,L,L,L,I,L,L,L,L,I.
- Timeout, TIMEOUT=8: slave never responds -> resp_valid with err=1, rdata=0 exactly 8 cycles after entering REQ; a late s_resp_valid in IDLE produces no output.
- Reset in WAIT: assert rst, then release; the slave then responds -> no resp_valid, all outputs 0; the next request is accepted normally.
- Same-cycle response and expiry at count TIMEOUT -> err=0, data = s_rdata.
